matrix_transpose_stream: RTL

//  Streaming tiled transpose engine with valid/ready flow control on both sides.

---
 rtl/matrix_transpose_pkg.sv | 39 +++
 rtl/transpose_tile_addr_gen.sv | 77 +++++++
 rtl/matrix_transpose_stream.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/matrix_transpose_pkg.sv
// Shared types and address helper for the tiled transpose engines.
// Address math is done at full 64-bit width and truncated by the caller.
package matrix_transpose_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int ADDR_MAX = 64;

   // Byte address of lane 0 of beat k from tile (tr,tc).
   // Transpose writes column k of the tile as a row of the transposed matrix.
   function automatic logic [ADDR_MAX-1:0] tile_addr(
      input logic [ADDR_MAX-1:0] dst,
      input logic [31:0]         tr,
      input logic [31:0]         tc,
      input logic [31:0]         k,
      input logic                bypass,
      input logic [31:0]         tile,
      input logic [31:0]         rows,
      input logic [31:0]         cols,
      input logic [31:0]         esize
   );
      logic [ADDR_MAX-1:0] elem;
      if (bypass) begin
         elem = (ADDR_MAX'(tr) * ADDR_MAX'(tile) + ADDR_MAX'(k))
              * ADDR_MAX'(cols)
              + ADDR_MAX'(tc) * ADDR_MAX'(tile);
      end else begin
         elem = (ADDR_MAX'(tc) * ADDR_MAX'(tile) + ADDR_MAX'(k))
              * ADDR_MAX'(rows)
              + ADDR_MAX'(tr) * ADDR_MAX'(tile);
      end
      return dst + elem * ADDR_MAX'(esize);
   endfunction

endpackage

// File: rtl/transpose_tile_addr_gen.sv
// Read-side tile walker: tracks (tr,tc) and beat k of the tile being drained,
// and produces the store address and end-of-session marker for each beat.
module transpose_tile_addr_gen
   import matrix_transpose_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int TILE       = 8,
   parameter int ARR_ROWS   = 16,
   parameter int ARR_COLS   = 16,
   parameter int ADDR_WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     consume,
   input  logic                     valid,
   input  logic                     bypass,
   input  logic [ADDR_WIDTH-1:0]    dst,
   output logic [$clog2(TILE)-1:0]  beat,
   output logic [ADDR_WIDTH-1:0]    addr,
   output logic                     last
);

   localparam int KW  = $clog2(TILE);
   localparam int NTR = ARR_ROWS / TILE;
   localparam int NTC = ARR_COLS / TILE;
   localparam int NT  = NTR * NTC;
   localparam int RW  = (NTR > 1) ? $clog2(NTR) : 1;
   localparam int CW  = (NTC > 1) ? $clog2(NTC) : 1;
   localparam int TW  = (NT > 1) ? $clog2(NT) : 1;

   localparam logic [KW-1:0] K_LAST = KW'(TILE - 1);
   localparam logic [RW-1:0] R_LAST = RW'(NTR - 1);
   localparam logic [CW-1:0] C_LAST = CW'(NTC - 1);
   localparam logic [TW-1:0] T_LAST = TW'(NT - 1);

   logic [KW-1:0]       k;
   logic [RW-1:0]       tr;
   logic [CW-1:0]       tc;
   logic [TW-1:0]       cnt;
   logic [ADDR_MAX-1:0] full_addr;

   // Tiles are drained in the same row-major order they were written.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         k   <= '0;
         tr  <= '0;
         tc  <= '0;
         cnt <= '0;
      end else if (consume) begin
         if (k == K_LAST) begin
            k   <= '0;
            cnt <= cnt + 1'b1;
            if (tc == C_LAST) begin
               tc <= '0;
               tr <= (tr == R_LAST) ? '0 : tr + 1'b1;
            end else begin
               tc <= tc + 1'b1;
            end
         end else begin
            k <= k + 1'b1;
         end
      end
   end

   always_comb begin
      full_addr = tile_addr(ADDR_MAX'(dst), 32'(tr), 32'(tc),
                            32'(k), bypass, 32'(TILE),
                            32'(ARR_ROWS), 32'(ARR_COLS),
                            32'(DATA_WIDTH / 8));
   end

   assign beat = k;
   assign addr = valid ? full_addr[ADDR_WIDTH-1:0] : '0;
   assign last = valid && (k == K_LAST) && (cnt == T_LAST);

endmodule

// File: rtl/matrix_transpose_stream.sv
// Streaming tiled transpose: rows in, tile columns out, ping-pong tile banks,
// valid/ready on both sides and a bypass mode that passes rows through.
module matrix_transpose_stream
   import matrix_transpose_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int TILE       = 8,
   parameter int ARR_ROWS   = 16,
   parameter int ARR_COLS   = 16,
   parameter int ADDR_WIDTH = 64
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              cfg_start,
   input  logic                              cfg_bypass,
   input  logic [ADDR_WIDTH-1:0]             cfg_dst_addr,
   output logic                              busy,
   output logic                              done,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [TILE-1:0][DATA_WIDTH-1:0]   in_row,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [TILE-1:0][DATA_WIDTH-1:0]   out_row,
   output logic [ADDR_WIDTH-1:0]             out_addr,
   output logic                              out_last
);

   localparam int KW = $clog2(TILE);
   localparam int NT = (ARR_ROWS / TILE) * (ARR_COLS / TILE);
   localparam int WW = $clog2(NT + 1);

   localparam logic [KW-1:0] K_LAST = KW'(TILE - 1);
   localparam logic [WW-1:0] NT_W   = WW'(NT);

   state_t                  state;
   logic                    bypass_q;
   logic [ADDR_WIDTH-1:0]   dst_q;
   logic [1:0]              full;
   logic                    wb;
   logic                    rb;
   logic [KW-1:0]           wr_r;
   logic [WW-1:0]           wr_cnt;
   logic [KW-1:0]           beat;
   logic                    last;
   logic                    start;
   logic                    accept;
   logic                    row_end;
   logic                    consume;
   logic                    beat_end;

   logic [TILE-1:0][DATA_WIDTH-1:0] tbuf [2][TILE];

   assign start    = cfg_start && (state == IDLE);
   assign in_ready = (state == RUN) && !full[wb] && (wr_cnt < NT_W);
   assign accept   = in_valid && in_ready;
   assign row_end  = accept && (wr_r == K_LAST);
   assign out_valid = full[rb];
   assign consume  = out_valid && out_ready;
   assign beat_end = consume && (beat == K_LAST);
   assign out_last = last;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         bypass_q <= 1'b0;
         dst_q    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (cfg_start) begin
                  state    <= RUN;
                  busy     <= 1'b1;
                  bypass_q <= cfg_bypass;
                  dst_q    <= cfg_dst_addr;
               end
            end
            RUN: begin
               if (consume && last) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // The bank being filled is never the one being drained, so both
   // flag updates may land in the same cycle on different bits.
   always_ff @(posedge clk) begin
      if (rst || start) begin
         full   <= '0;
         wb     <= 1'b0;
         rb     <= 1'b0;
         wr_r   <= '0;
         wr_cnt <= '0;
      end else begin
         if (accept) begin
            wr_r <= row_end ? '0 : wr_r + 1'b1;
         end
         if (row_end) begin
            wb         <= !wb;
            wr_cnt     <= wr_cnt + 1'b1;
            full[wb]   <= 1'b1;
         end
         if (beat_end) begin
            rb         <= !rb;
            full[rb]   <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         tbuf[wb][wr_r] <= in_row;
      end
   end

   always_comb begin
      out_row = '0;
      if (out_valid) begin
         for (int j = 0; j < TILE; j++) begin
            out_row[KW'(j)] = bypass_q ? tbuf[rb][beat][KW'(j)]
                                       : tbuf[rb][KW'(j)][beat];
         end
      end
   end

   transpose_tile_addr_gen #(
      .DATA_WIDTH (DATA_WIDTH),
      .TILE       (TILE),
      .ARR_ROWS   (ARR_ROWS),
      .ARR_COLS   (ARR_COLS),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr (
      .clk     (clk),
      .rst     (rst),
      .clear   (start),
      .consume (consume),
      .valid   (out_valid),
      .bypass  (bypass_q),
      .dst     (dst_q),
      .beat    (beat),
      .addr    (out_addr),
      .last    (last)
   );

endmodule
